// File: rtl/id_hazard_fwd_unit.sv
// Decode-side operand forwarding, load-use hazard detection and ID/EX pipeline register.
// A shift-register scoreboard tracks loads that have not yet produced data on a forwarding source.
module id_hazard_fwd_unit #(
  parameter int XLEN        = 32,
  parameter int RA_W        = 5,
  parameter int NUM_FWD     = 3,
  parameter int LOAD_LAT    = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    id_valid_i,
  input  logic [RA_W-1:0]         id_rs1_i,
  input  logic [RA_W-1:0]         id_rs2_i,
  input  logic                    id_use_rs1_i,
  input  logic                    id_use_rs2_i,
  input  logic [RA_W-1:0]         id_rd_i,
  input  logic                    id_reg_write_i,
  input  logic                    id_is_load_i,
  input  logic [XLEN-1:0]         rf_rs1_data_i,
  input  logic [XLEN-1:0]         rf_rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
  input  logic                    ex_ready_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    ex_valid_o,
  output logic [XLEN-1:0]         ex_rs1_data_o,
  output logic [XLEN-1:0]         ex_rs2_data_o,
  output logic [RA_W-1:0]         ex_rd_o,
  output logic                    ex_reg_write_o,
  output logic                    ex_is_load_o,
  output logic [STALL_CNT_W-1:0]  stall_cnt_o
);

  logic [RA_W-1:0] fwd_rd_a   [NUM_FWD];
  logic [XLEN-1:0] fwd_data_a [NUM_FWD];

  for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_unpack
    assign fwd_rd_a[gi]   = fwd_rd_i[gi*RA_W +: RA_W];
    assign fwd_data_a[gi] = fwd_data_i[gi*XLEN +: XLEN];
  end

  // Descending scan so the youngest matching source (lowest index) wins.
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  always_comb begin
    rs1_fwd = rf_rs1_data_i;
    rs2_fwd = rf_rs2_data_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && fwd_rd_a[k] == id_rs1_i) rs1_fwd = fwd_data_a[k];
      if (fwd_valid_i[k] && fwd_rd_a[k] == id_rs2_i) rs2_fwd = fwd_data_a[k];
    end
    if (id_rs1_i == '0) rs1_fwd = '0;
    if (id_rs2_i == '0) rs2_fwd = '0;
  end

  logic [LOAD_LAT-1:0] sb_valid_q, sb_valid_d;
  logic [RA_W-1:0]     sb_rd_q [LOAD_LAT];
  logic [RA_W-1:0]     sb_rd_d [LOAD_LAT];
  logic                hit;
  logic                issue;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_valid_q[i] && id_use_rs1_i && id_rs1_i != '0 && sb_rd_q[i] == id_rs1_i) hit = 1'b1;
      if (sb_valid_q[i] && id_use_rs2_i && id_rs2_i != '0 && sb_rd_q[i] == id_rs2_i) hit = 1'b1;
    end
  end

  assign stall_o = id_valid_i & hit & ~flush_i;
  assign issue   = id_valid_i & ~stall_o & ex_ready_i & ~flush_i;

  // A flush kills the load leaving EX (moving into slot 1) as well as anything entering slot 0.
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_rd_d    = sb_rd_q;
    if (ex_ready_i || flush_i) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        sb_valid_d[i] = sb_valid_q[i-1] & ~(flush_i && i == 1);
        sb_rd_d[i]    = sb_rd_q[i-1];
      end
      sb_valid_d[0] = issue & id_is_load_i & id_reg_write_i & (id_rd_i != '0);
      sb_rd_d[0]    = id_rd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sb_valid_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_rd_q[i] <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_rd_q    <= sb_rd_d;
    end
  end

  logic                   ex_valid_q, ex_reg_write_q, ex_is_load_q;
  logic [XLEN-1:0]        ex_rs1_q, ex_rs2_q;
  logic [RA_W-1:0]        ex_rd_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_q     <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
    end else if (flush_i) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
    end else if (ex_ready_i) begin
      ex_valid_q     <= issue;
      ex_rs1_q       <= rs1_fwd;
      ex_rs2_q       <= rs2_fwd;
      ex_rd_q        <= id_rd_i;
      ex_reg_write_q <= issue & id_reg_write_i;
      ex_is_load_q   <= issue & id_is_load_i;
    end
  end

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_rs1_data_o  = ex_rs1_q;
  assign ex_rs2_data_o  = ex_rs2_q;
  assign ex_rd_o        = ex_rd_q;
  assign ex_reg_write_o = ex_reg_write_q;
  assign ex_is_load_o   = ex_is_load_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Randomized scoreboard bench: the driver predicts each issued EX entry from a load-age model,
// and a negedge monitor pops and compares whenever EX hands an entry downstream.
module tb_id_hazard_fwd_unit;
  localparam int XLEN = 32, RA_W = 5, NUM_FWD = 3, LOAD_LAT = 2, CW = 4;
  localparam int N_CYC = 700;

  logic clk = 1'b0;
  logic rst_i;
  logic id_valid_i, id_use_rs1_i, id_use_rs2_i, id_reg_write_i, id_is_load_i;
  logic [RA_W-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [XLEN-1:0] rf_rs1_data_i, rf_rs2_data_i;
  logic [NUM_FWD-1:0] fwd_valid_i;
  logic [NUM_FWD*RA_W-1:0] fwd_rd_i;
  logic [NUM_FWD*XLEN-1:0] fwd_data_i;
  logic ex_ready_i, flush_i;
  logic stall_o, ex_valid_o, ex_reg_write_o, ex_is_load_o;
  logic [XLEN-1:0] ex_rs1_data_o, ex_rs2_data_o;
  logic [RA_W-1:0] ex_rd_o;
  logic [CW-1:0] stall_cnt_o;

  id_hazard_fwd_unit #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT),
                       .STALL_CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i), .id_is_load_i(id_is_load_i),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i), .fwd_valid_i(fwd_valid_i),
    .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_is_load_o(ex_is_load_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RA_W-1:0] rd;
    logic            rw;
    logic            ld;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  int   n_checks = 0, n_errors = 0, n_txn = 0;

  // Model state: loads still in flight as (rd, advances since entering EX).
  int   pend_rd[$], pend_age[$];
  logic m_ev;
  int   m_cnt;
  logic exp_stall, exp_ev;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_operand(input logic [RA_W-1:0] rs,
      input logic [XLEN-1:0] rf, input logic [NUM_FWD-1:0] fv,
      input logic [NUM_FWD*RA_W-1:0] frd, input logic [NUM_FWD*XLEN-1:0] fd);
    if (rs == 0) return '0;
    for (int k = 0; k < NUM_FWD; k++)
      if (fv[k] && frd[k*RA_W +: RA_W] == rs) return fd[k*XLEN +: XLEN];
    return rf;
  endfunction

  task automatic set_idle();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
    id_rd_i = 0; id_reg_write_i = 0; id_is_load_i = 0; rf_rs1_data_i = 0; rf_rs2_data_i = 0;
    fwd_valid_i = 0; fwd_rd_i = 0; fwd_data_i = 0; ex_ready_i = 1; flush_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    set_idle();
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_ex_valid", ex_valid_o, 0);
    chk("rst_rs1", ex_rs1_data_o, 0);
    chk("rst_rs2", ex_rs2_data_o, 0);
    chk("rst_rd", ex_rd_o, 0);
    chk("rst_rw", ex_reg_write_o, 0);
    chk("rst_ld", ex_is_load_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    exq.delete(); pend_rd.delete(); pend_age.delete();
    m_ev = 0; m_cnt = 0;
    exp_stall = 0; exp_ev = 0; exp_cnt = 0;
  endtask

  task automatic do_cycle(input bit drain);
    logic hit, m_stall, m_issue;
    int nrd[$], nage[$];
    rst_i = 1'b1;
    if (drain) set_idle();
    else begin
      id_valid_i     = ($urandom_range(0, 99) < 85);
      id_rs1_i       = RA_W'($urandom_range(0, 3));
      id_rs2_i       = RA_W'($urandom_range(0, 3));
      id_use_rs1_i   = ($urandom_range(0, 99) < 80);
      id_use_rs2_i   = ($urandom_range(0, 99) < 60);
      id_rd_i        = RA_W'($urandom_range(0, 3));
      id_reg_write_i = ($urandom_range(0, 99) < 85);
      id_is_load_i   = ($urandom_range(0, 99) < 40);
      rf_rs1_data_i  = $urandom;
      rf_rs2_data_i  = $urandom;
      fwd_valid_i    = NUM_FWD'($urandom);
      for (int k = 0; k < NUM_FWD; k++) begin
        fwd_rd_i[k*RA_W +: RA_W]   = RA_W'($urandom_range(0, 3));
        fwd_data_i[k*XLEN +: XLEN] = $urandom;
      end
      ex_ready_i = ($urandom_range(0, 99) < 75);
      flush_i    = ($urandom_range(0, 99) < 6);
    end

    hit = 0;
    foreach (pend_rd[j]) begin
      if (id_use_rs1_i && id_rs1_i != 0 && pend_rd[j] == int'(id_rs1_i)) hit = 1;
      if (id_use_rs2_i && id_rs2_i != 0 && pend_rd[j] == int'(id_rs2_i)) hit = 1;
    end
    m_stall = id_valid_i && hit && !flush_i;
    m_issue = id_valid_i && !m_stall && ex_ready_i && !flush_i;

    exp_stall = m_stall; exp_ev = m_ev; exp_cnt = m_cnt;
    if (flush_i) exq.delete();
    if (m_issue)
      exq.push_back('{a: ref_operand(id_rs1_i, rf_rs1_data_i, fwd_valid_i, fwd_rd_i, fwd_data_i),
                      b: ref_operand(id_rs2_i, rf_rs2_data_i, fwd_valid_i, fwd_rd_i, fwd_data_i),
                      rd: id_rd_i, rw: id_reg_write_i, ld: id_is_load_i});

    if (flush_i) m_ev = 0;
    else if (ex_ready_i) m_ev = m_issue;
    if (m_stall && m_cnt != (1 << CW) - 1) m_cnt++;

    if (flush_i || ex_ready_i) begin
      foreach (pend_rd[j]) begin
        if (flush_i && pend_age[j] == 0) continue;
        if (pend_age[j] + 1 < LOAD_LAT) begin
          nrd.push_back(pend_rd[j]);
          nage.push_back(pend_age[j] + 1);
        end
      end
      if (m_issue && id_is_load_i && id_reg_write_i && id_rd_i != 0) begin
        nrd.push_back(int'(id_rd_i));
        nage.push_back(0);
      end
      pend_rd = nrd; pend_age = nage;
    end
  endtask

  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      chk("stall_o", stall_o, exp_stall);
      chk("ex_valid_o", ex_valid_o, exp_ev);
      chk("stall_cnt_o", stall_cnt_o, exp_cnt);
      if (!ex_valid_o) chk("ex_rw_idle", ex_reg_write_o, 0);
      if (ex_valid_o && ex_ready_i && !flush_i) begin
        if (exq.size() == 0) chk("ex_unexpected_entry", 1, 0);
        else begin
          mon_e = exq.pop_front();
          chk("ex_rs1_data", ex_rs1_data_o, mon_e.a);
          chk("ex_rs2_data", ex_rs2_data_o, mon_e.b);
          chk("ex_rd", ex_rd_o, mon_e.rd);
          chk("ex_reg_write", ex_reg_write_o, mon_e.rw);
          chk("ex_is_load", ex_is_load_o, mon_e.ld);
          n_txn++;
          $display("txn %0d rd=%0d rw=%0b ld=%0b a=%h b=%h", n_txn, ex_rd_o, ex_reg_write_o,
                   ex_is_load_o, ex_rs1_data_o, ex_rs2_data_o);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    set_idle();
    #2;
    for (int i = 0; i < N_CYC; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      if (i < 2 || i % 150 == 149) do_reset();
      else do_cycle(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      do_cycle(1'b1);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", exq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
